// File: rtl/collision_scanner_if.sv
// Collision event stream between the scanner (master) and its consumer (slave).
interface collision_scanner_if;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_type;
  logic [9:0] event_a_addr;
  logic [9:0] event_b_addr;

  modport master (
    output event_valid, event_type, event_a_addr, event_b_addr,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_type, event_a_addr, event_b_addr,
    output event_ready
  );
endinterface

// File: rtl/collision_scanner.sv
// Walks ship/asteroid, shot/asteroid and shot/bounds candidates once per start,
// one candidate per unstalled cycle; a pending unaccepted event freezes the walk.
module collision_scanner #(
  parameter int MAX_SHOTS     = 3,
  parameter int MAX_ASTEROIDS = 3,
  parameter int ENTITY_SIZE   = 34,
  parameter int SHIP_DIM      = 22,
  parameter int AST_DIM       = 22,
  parameter int SHOT_DIM      = 2,
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240,
  parameter int LIVES_INIT    = 3
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [ENTITY_SIZE-1:0]                    ship,
  input  logic [MAX_ASTEROIDS-1:0][ENTITY_SIZE-1:0] asteroids,
  input  logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0]     shots,
  collision_scanner_if.master                       evt,
  output logic                                      busy,
  output logic                                      done,
  output logic [3:0]                                lives,
  output logic                                      game_over
);

  localparam int AW = (MAX_ASTEROIDS > 1) ? $clog2(MAX_ASTEROIDS) : 1;
  localparam int SW = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
  localparam logic [AW-1:0] LAST_A = AW'(MAX_ASTEROIDS - 1);
  localparam logic [SW-1:0] LAST_S = SW'(MAX_SHOTS - 1);
  localparam logic [10:0] SHIP_D = 11'(SHIP_DIM);
  localparam logic [10:0] AST_D  = 11'(AST_DIM);
  localparam logic [10:0] SHOT_D = 11'(SHOT_DIM);
  localparam logic [10:0] SCR_W  = 11'(SCREEN_W);
  localparam logic [10:0] SCR_H  = 11'(SCREEN_H);

  typedef enum logic [2:0] {S_IDLE, S_SHIP, S_PAIR, S_BOUNDS, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            ai_q, ai_d;
  logic [SW-1:0]            sj_q, sj_d;
  logic [MAX_ASTEROIDS-1:0] ast_dead_q, ast_dead_d;
  logic [MAX_SHOTS-1:0]     shot_dead_q, shot_dead_d;
  logic                     ship_hit_q, ship_hit_d;
  logic                     ev_vld_q, ev_vld_d;
  logic [1:0]               ev_type_q, ev_type_d;
  logic [9:0]               ev_a_q, ev_a_d;
  logic [9:0]               ev_b_q, ev_b_d;
  logic                     done_q, done_d;
  logic [3:0]               lives_q, lives_d;
  logic                     game_over_q;
  logic                     eval;

  logic [ENTITY_SIZE-1:0] ast_w, shot_w;
  logic [10:0] ship_x, ship_y, ast_x, ast_y, shot_x, shot_y;
  logic        unused_bits;

  assign ast_w  = asteroids[ai_q];
  assign shot_w = shots[sj_q];
  assign ship_x = {1'b0, ship[15:6]};
  assign ship_y = {1'b0, ship[25:16]};
  assign ast_x  = {1'b0, ast_w[15:6]};
  assign ast_y  = {1'b0, ast_w[25:16]};
  assign shot_x = {1'b0, shot_w[15:6]};
  assign shot_y = {1'b0, shot_w[25:16]};
  // Reserved word bits carry no collision meaning.
  assign unused_bits = ^{ship, asteroids, shots};

  function automatic logic overlap(input logic [10:0] ax, input logic [10:0] ay,
                                   input logic [10:0] da, input logic [10:0] bx,
                                   input logic [10:0] by, input logic [10:0] db);
    return (ax < bx + db) && (bx < ax + da) && (ay < by + db) && (by < ay + da);
  endfunction

  assign eval = !ev_vld_q || evt.event_ready;

  always_comb begin
    state_d     = state_q;
    ai_d        = ai_q;
    sj_d        = sj_q;
    ast_dead_d  = ast_dead_q;
    shot_dead_d = shot_dead_q;
    ship_hit_d  = ship_hit_q;
    ev_vld_d    = ev_vld_q && !evt.event_ready;
    ev_type_d   = ev_type_q;
    ev_a_d      = ev_a_q;
    ev_b_d      = ev_b_q;
    done_d      = 1'b0;
    lives_d     = lives_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SHIP;
          ai_d        = '0;
          sj_d        = '0;
          ast_dead_d  = '0;
          shot_dead_d = '0;
          ship_hit_d  = 1'b0;
        end
      end
      S_SHIP: begin
        if (eval) begin
          if (ship[ENTITY_SIZE-1] && ast_w[ENTITY_SIZE-1] && !ship_hit_q &&
              overlap(ship_x, ship_y, SHIP_D, ast_x, ast_y, AST_D)) begin
            ev_vld_d   = 1'b1;
            ev_type_d  = 2'd0;
            ev_a_d     = 10'(ai_q);
            ev_b_d     = '0;
            ship_hit_d = 1'b1;
            if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
          end
          if (ai_q == LAST_A) begin
            ai_d    = '0;
            state_d = S_PAIR;
          end else begin
            ai_d = ai_q + 1'b1;
          end
        end
      end
      S_PAIR: begin
        if (eval) begin
          if (ast_w[ENTITY_SIZE-1] && !ast_dead_q[ai_q] &&
              shot_w[ENTITY_SIZE-1] && !shot_dead_q[sj_q] &&
              overlap(ast_x, ast_y, AST_D, shot_x, shot_y, SHOT_D)) begin
            ev_vld_d          = 1'b1;
            ev_type_d         = 2'd1;
            ev_a_d            = 10'(ai_q);
            ev_b_d            = 10'(sj_q);
            ast_dead_d[ai_q]  = 1'b1;
            shot_dead_d[sj_q] = 1'b1;
          end
          if (sj_q == LAST_S) begin
            sj_d = '0;
            if (ai_q == LAST_A) begin
              ai_d    = '0;
              state_d = S_BOUNDS;
            end else begin
              ai_d = ai_q + 1'b1;
            end
          end else begin
            sj_d = sj_q + 1'b1;
          end
        end
      end
      S_BOUNDS: begin
        if (eval) begin
          if (shot_w[ENTITY_SIZE-1] && !shot_dead_q[sj_q] &&
              (shot_x >= SCR_W || shot_y >= SCR_H)) begin
            ev_vld_d          = 1'b1;
            ev_type_d         = 2'd2;
            ev_a_d            = 10'(sj_q);
            ev_b_d            = '0;
            shot_dead_d[sj_q] = 1'b1;
          end
          if (sj_q == LAST_S) begin
            sj_d    = '0;
            state_d = S_DONE;
          end else begin
            sj_d = sj_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (eval) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ai_q        <= '0;
      sj_q        <= '0;
      ast_dead_q  <= '0;
      shot_dead_q <= '0;
      ship_hit_q  <= 1'b0;
      ev_vld_q    <= 1'b0;
      ev_type_q   <= '0;
      ev_a_q      <= '0;
      ev_b_q      <= '0;
      done_q      <= 1'b0;
      lives_q     <= 4'(LIVES_INIT);
      game_over_q <= (LIVES_INIT == 0);
    end else begin
      state_q     <= state_d;
      ai_q        <= ai_d;
      sj_q        <= sj_d;
      ast_dead_q  <= ast_dead_d;
      shot_dead_q <= shot_dead_d;
      ship_hit_q  <= ship_hit_d;
      ev_vld_q    <= ev_vld_d;
      ev_type_q   <= ev_type_d;
      ev_a_q      <= ev_a_d;
      ev_b_q      <= ev_b_d;
      done_q      <= done_d;
      lives_q     <= lives_d;
      game_over_q <= (lives_d == 4'd0);
    end
  end

  assign evt.event_valid  = ev_vld_q;
  assign evt.event_type   = ev_type_q;
  assign evt.event_a_addr = ev_a_q;
  assign evt.event_b_addr = ev_b_q;
  assign busy      = (state_q == S_SHIP) || (state_q == S_PAIR) || (state_q == S_BOUNDS);
  assign done      = done_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Randomized and directed scans of collision_scanner against a loop-based event model.
module tb_collision_scanner;
  logic             clk = 1'b0;
  logic             reset, start;
  logic [33:0]      ship;
  logic [2:0][33:0] asts, shots;
  logic             busy, done, game_over;
  logic [3:0]       lives;
  int               n_chk = 0, n_err = 0;
  int               m_lives = 3;
  logic [21:0]      exp_q[$];
  int               last_stalls;

  collision_scanner_if evt_bus ();

  collision_scanner dut (
    .clk(clk), .reset(reset), .start(start), .ship(ship), .asteroids(asts),
    .shots(shots), .evt(evt_bus), .busy(busy), .done(done), .lives(lives),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] mk(input bit v, input int x, input int y);
    logic [33:0] w;
    w = '0;
    w[33] = v;
    w[15:6] = 10'(x);
    w[25:16] = 10'(y);
    return w;
  endfunction

  function automatic int px(input logic [33:0] w); return int'(w[15:6]); endfunction
  function automatic int py(input logic [33:0] w); return int'(w[25:16]); endfunction

  function automatic bit ovl(input logic [33:0] a, input int da, input logic [33:0] b, input int db);
    return px(a) < px(b) + db && px(b) < px(a) + da && py(a) < py(b) + db && py(b) < py(a) + da;
  endfunction

  // Expected event list for one frame from the current tables.
  task automatic build_model();
    bit sh_hit = 0;
    bit ad[3] = '{0, 0, 0};
    bit sd[3] = '{0, 0, 0};
    exp_q.delete();
    for (int i = 0; i < 3; i++)
      if (ship[33] && asts[i][33] && !sh_hit && ovl(ship, 22, asts[i], 22)) begin
        exp_q.push_back({2'd0, 10'(i), 10'd0});
        sh_hit = 1;
        if (m_lives > 0) m_lives--;
      end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (asts[i][33] && !ad[i] && shots[j][33] && !sd[j] && ovl(asts[i], 22, shots[j], 2)) begin
          exp_q.push_back({2'd1, 10'(i), 10'(j)});
          ad[i] = 1;
          sd[j] = 1;
        end
    for (int j = 0; j < 3; j++)
      if (shots[j][33] && !sd[j] && (px(shots[j]) >= 320 || py(shots[j]) >= 240)) begin
        exp_q.push_back({2'd2, 10'(j), 10'd0});
        sd[j] = 1;
      end
  endtask

  // mode 0: ready high; 1: random ready; 2: first five pending-event edges refused
  task automatic run_scan(input int mode, input string tag);
    logic [21:0] got_q[$];
    logic [21:0] cur, hold_v;
    int   stalls = 0, edges = 0;
    bit   seen = 0, held = 0, rdy;
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
    while (!seen && edges < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (stalls >= 5);
      endcase
      evt_bus.event_ready = rdy;
      start = ($urandom_range(0, 3) == 0);
      cur = {evt_bus.event_type, evt_bus.event_a_addr, evt_bus.event_b_addr};
      if (held) chk({tag, "_hold"}, {evt_bus.event_valid, cur}, {1'b1, hold_v});
      held = 0;
      if (evt_bus.event_valid) begin
        if (rdy) got_q.push_back(cur);
        else begin
          stalls++;
          held = 1;
          hold_v = cur;
        end
      end
      @(negedge clk);
      edges++;
      seen = done;
    end
    start = 1'b0;
    evt_bus.event_ready = 1'b1;
    last_stalls = stalls;
    chk({tag, "_done_edge"}, 32'(edges), 32'(16 + stalls));
    chk({tag, "_nev"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk({tag, "_ev"}, 32'(got_q[k]), 32'(exp_q[k]));
    chk({tag, "_lives"}, 32'(lives), 32'(m_lives));
    chk({tag, "_gover"}, 32'(game_over), 32'(m_lives == 0));
    chk({tag, "_vld_end"}, 32'(evt_bus.event_valid), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_lives = 3;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vld"}, 32'(evt_bus.event_valid), 0);
    chk({tag, "_pay"}, {evt_bus.event_type, evt_bus.event_a_addr, evt_bus.event_b_addr}, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_lives"}, 32'(lives), 3);
    chk({tag, "_gover"}, 32'(game_over), 0);
  endtask

  task automatic clear_tables();
    ship = '0;
    asts = '0;
    shots = '0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; evt_bus.event_ready = 1'b1;
    clear_tables();
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    reset = 1'b0;

    ship = mk(1, 14, 14); asts[0] = mk(1, 20, 20);
    run_scan(0, "ship_hit");

    clear_tables();
    ship = mk(1, 300, 10); asts[1] = mk(1, 100, 100);
    shots[0] = mk(1, 105, 105); shots[2] = mk(1, 105, 105);
    run_scan(0, "shot_ast");

    clear_tables();
    shots[1] = mk(1, 320, 5);
    run_scan(2, "oob_stall");
    chk("oob_stall_cnt", 32'(last_stalls), 5);

    clear_tables();
    asts[0] = mk(1, 50, 50); shots[0] = mk(1, 72, 50);
    run_scan(0, "edge_touch");
    shots[0] = mk(1, 71, 50);
    run_scan(0, "edge_overlap");

    do_reset();
    clear_tables();
    ship = mk(1, 40, 40); asts[2] = mk(1, 45, 50);
    for (int k = 0; k < 4; k++) run_scan(1, "lives");
    chk("lives_floor", 32'(lives), 0);

    clear_tables();
    asts[1] = mk(1, 100, 100); shots[0] = mk(1, 105, 105);
    evt_bus.event_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!evt_bus.event_valid && n < 40) begin @(negedge clk); n++; end
    chk("mid_pair_type", {evt_bus.event_valid, evt_bus.event_type}, {1'b1, 2'd1});
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("mid_rst");
    reset = 1'b0; evt_bus.event_ready = 1'b1; m_lives = 3;
    @(negedge clk);
    chk("mid_rst_stay", 32'(busy), 0);

    for (int t = 0; t < 40; t++) begin
      if (t % 10 == 0) do_reset();
      ship = mk($urandom_range(0, 3) != 0, $urandom_range(0, 120), $urandom_range(0, 120));
      for (int i = 0; i < 3; i++)
        asts[i] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 120), $urandom_range(0, 120));
      for (int j = 0; j < 3; j++)
        if ($urandom_range(0, 3) == 0)
          shots[j] = mk($urandom_range(0, 3) != 0, $urandom_range(300, 340), $urandom_range(0, 260));
        else
          shots[j] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 140), $urandom_range(0, 140));
      run_scan(1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/collision_scanner.md
COLLISION_SCANNER -- requirements
Module: collision_scanner

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- MAX_SHOTS, 3, shot slots.
- MAX_ASTEROIDS, 3, asteroid slots.
- ENTITY_SIZE, 34, entity word width; bit ENTITY_SIZE-1 = valid, [15:6] = x, [25:16] = y.
- SHIP_DIM, 22, ship box side in px.
- AST_DIM, 22, asteroid box side in px.
- SHOT_DIM, 2, shot box side in px.
- SCREEN_W, 320, playfield width.
- SCREEN_H, 240, playfield height.
- LIVES_INIT, 3, lives after reset.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, begin one frame scan.
- ship, in, ENTITY_SIZE, ship word.
- asteroids, in, MAX_ASTEROIDS x ENTITY_SIZE, asteroid table.
- shots, in, MAX_SHOTS x ENTITY_SIZE, shot table.
- event_valid, out, 1, event pending.
- event_ready, in, 1, consumer accepts event.
- event_type, out, 2, 0 = SHIP_HIT, 1 = SHOT_AST, 2 = SHOT_OOB.
- event_a_addr, out, 10, asteroid index (SHIP_HIT, SHOT_AST) or shot index (SHOT_OOB).
- event_b_addr, out, 10, shot index for SHOT_AST, else 0.
- busy, out, 1, scan in progress.
- done, out, 1, one-cycle end-of-scan pulse.
- lives, out, 4, remaining lives.
- game_over, out, 1, lives == 0.

Function
REQ-003 FSM states SHALL be IDLE, SHIP, PAIR, BOUNDS, DONE; busy = 1 in SHIP, PAIR and BOUNDS.
REQ-004 IDLE with start = 1 SHALL enter SHIP with indices cleared and shot_dead/ast_dead masks cleared; start in any other state SHALL be ignored.
REQ-005 SHIP SHALL test asteroid i = 0..MAX_ASTEROIDS-1, one per evaluation cycle; PAIR SHALL test (i, j) with i outer and j = 0..MAX_SHOTS-1 inner, one per evaluation cycle; BOUNDS SHALL test shot j = 0..MAX_SHOTS-1, one per evaluation cycle; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-006 An evaluation cycle SHALL occur only when event_valid = 0 or event_ready = 1; otherwise the FSM and indices SHALL hold.
REQ-007 Overlap of box A (ax, ay, side da) and box B (bx, by, side db) SHALL be ax < bx+db AND bx < ax+da AND ay < by+db AND by < ay+da, computed in 11-bit unsigned arithmetic with no wrap.
REQ-008 SHIP hit SHALL require both ship and asteroid valid plus overlap; at most one SHIP_HIT per scan (first in index order); subsequent ship overlaps in the same scan SHALL be ignored.
REQ-009 PAIR hit SHALL require asteroid valid and not ast_dead, shot valid and not shot_dead, plus overlap; on hit set ast_dead[i] and shot_dead[j], emit SHOT_AST (a = i, b = j).
REQ-010 BOUNDS hit SHALL require shot valid, not shot_dead, and (x >= SCREEN_W or y >= SCREEN_H); emit SHOT_OOB (a = j), set shot_dead[j].
REQ-011 A hit SHALL load event_* on the evaluating edge; event_valid SHALL stay high with stable payload until an edge with event_ready = 1, then clear unless a new hit loads on that same edge.
REQ-012 With event_ready held high, done SHALL rise exactly MAX_ASTEROIDS + MAX_ASTEROIDS*MAX_SHOTS + MAX_SHOTS + 1 edges after the edge sampling start, independent of hit count.
REQ-013 DONE SHALL not exit while event_valid = 1 and event_ready = 0.
REQ-014 On SHIP_HIT load, lives SHALL decrement by 1, saturating at 0; game_over SHALL equal (lives == 0) as a registered output.
REQ-015 Table inputs SHALL be sampled live during scan; the caller holds them stable while busy.

Reset
REQ-016 reset = 1 at any edge, including mid-scan or with an event pending, SHALL force IDLE, event_valid = 0, event_type = 0, both addresses = 0, busy = 0, done = 0, masks cleared, lives = LIVES_INIT, game_over = (LIVES_INIT == 0); reset SHALL override start.

Verification
REQ-017 Ship (14,14) valid, asteroid0 (20,20) valid, no shots, ready = 1, start -> one SHIP_HIT a = 0, lives 3 -> 2, done at edge 16 (defaults).
REQ-018 Asteroid1 (100,100), shots 0 and 2 at (105,105), ship at (300,10) -> exactly one SHOT_AST a = 1, b = 0; shot2 generates no event.
REQ-019 Shot1 at x = 320, y = 5, ready = 0 for 5 cycles after event -> SHOT_OOB a = 1 held stable, FSM stalled, done delayed 5 cycles.
REQ-020 Boxes touching edge-on (asteroid x = 50, shot x = 72 with AST_DIM 22) -> no event; shot x = 71 -> SHOT_AST.
REQ-021 Four scans each with a ship overlap -> lives 3, 2, 1, 0, 0; game_over = 1 after the third; start during busy ignored.
REQ-022 reset asserted while event_valid = 1 mid-PAIR -> next cycle IDLE, all outputs at reset values, lives = 3.
